// File: rtl/imem_load_arb_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
// Included by the arbiter, its RAM interface and the RAM itself.
package imem_load_arb_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_AW    = 5;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Misaligned or beyond the 32-word window.
  function automatic logic addr_bad(
    input logic [31:0] a
  );
    return (a[1:0] != 2'b00) |
           (a[31:7] != 25'd0);
  endfunction

endpackage

// File: rtl/imem_load_arb_if.sv
// RAM port bundle between the load arbiter and imem_ram.
// One synchronous write port, one combinational read port.
interface imem_load_arb_if;
  import imem_load_arb_pkg::*;

  logic               we;
  logic [IMEM_AW-1:0] waddr;
  logic [31:0]        wdata;
  logic [IMEM_AW-1:0] raddr;
  logic [31:0]        rdata;

  modport master (
    output we,
    output waddr,
    output wdata,
    output raddr,
    input  rdata
  );

  modport slave (
    input  we,
    input  waddr,
    input  wdata,
    input  raddr,
    output rdata
  );

endinterface

// File: rtl/imem_ram.sv
// 32x32 instruction RAM: synchronous write, asynchronous read.
// Contents are not reset; the arbiter rewrites every word on load.
module imem_ram
  import imem_load_arb_pkg::*;
(
  input logic             clk,
  imem_load_arb_if.slave  mem
);

  logic [31:0] r_mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem.we) begin
      r_mem[mem.waddr] <= mem.wdata;
    end
  end

  assign mem.rdata = r_mem[mem.raddr];

endmodule

// File: rtl/imem_load_arb.sv
// Program-load arbiter: streams loader words into IMEM, pads the
// tail with NOPs, then serves zero-latency CPU fetches.
module imem_load_arb
  import imem_load_arb_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic               load_req,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               ld_done,
  input  logic [31:0]        fetch_addr,
  output logic [31:0]        fetch_inst,
  output logic               fetch_err,
  output logic               cpu_stall,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_waddr,
  output logic [31:0]        mem_wdata,
  output logic [IMEM_AW-1:0] mem_raddr,
  input  logic [31:0]        mem_rdata
);

  localparam logic [5:0] LAST = 6'(DEPTH - 1);

  state_e     r_state;
  state_e     w_state_nx;
  logic [5:0] r_wcnt;
  logic [5:0] w_wcnt_nx;
  logic       r_done;
  logic       w_done_nx;
  logic       w_load;
  logic       w_fill;
  logic       w_run;
  logic       w_end;

  assign w_load = (r_state == ST_LOAD);
  assign w_fill = (r_state == ST_FILL);
  assign w_run  = (r_state == ST_RUN);
  assign w_end  = ld_last | (r_wcnt == LAST);

  always_comb begin
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    w_done_nx  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          w_state_nx = ST_LOAD;
          w_wcnt_nx  = 6'd0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          w_wcnt_nx = r_wcnt + 6'd1;
          if (w_end) begin
            // Short program: pad the rest with NOPs first.
            if (r_wcnt < LAST) begin
              w_state_nx = ST_FILL;
            end else begin
              w_state_nx = ST_RUN;
              w_done_nx  = 1'b1;
            end
          end
        end
      end
      ST_FILL: begin
        w_wcnt_nx = r_wcnt + 6'd1;
        if (r_wcnt == LAST) begin
          w_state_nx = ST_RUN;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 6'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
      r_done  <= w_done_nx;
    end
  end

  assign ld_ready  = w_load;
  assign ld_done   = r_done;
  assign cpu_stall = ~w_run;

  assign mem_we    = (w_load & ld_valid) | w_fill;
  assign mem_waddr = r_wcnt[IMEM_AW-1:0];
  assign mem_wdata = w_load ? ld_data : NOP_WORD;

  assign mem_raddr  = fetch_addr[6:2];
  assign fetch_err  = addr_bad(fetch_addr);
  assign fetch_inst = (w_run & ~fetch_err) ? mem_rdata
                                           : NOP_WORD;

endmodule

// File: tb/tb_imem_load_arb.sv
// Directed bench for imem_load_arb with imem_ram beside it.
// Fetch vectors are table-driven; load flows are hand sequences.
module tb_imem_load_arb;
  import imem_load_arb_pkg::*;

  logic        Clk;
  logic        Clrn;
  logic        load_req;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_inst;
  logic        fetch_err;
  logic        cpu_stall;

  imem_load_arb_if mif();

  imem_load_arb dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .load_req   (load_req),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .fetch_addr (fetch_addr),
    .fetch_inst (fetch_inst),
    .fetch_err  (fetch_err),
    .cpu_stall  (cpu_stall),
    .mem_we     (mif.we),
    .mem_waddr  (mif.waddr),
    .mem_wdata  (mif.wdata),
    .mem_raddr  (mif.raddr),
    .mem_rdata  (mif.rdata)
  );

  imem_ram u_ram (
    .clk (Clk),
    .mem (mif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int g;
    g = 0;
    while (!ld_done && g < 100) begin
      tick();
      g++;
    end
    chk(nm, 32'(ld_done), 32'd1);
  endtask

  logic [31:0] w3 [3];
  int n;

  initial begin
    vt[0] = '{32'h0000_0000, 32'h2041_0010, 1'b0};
    vt[1] = '{32'h0000_0004, 32'h2041_0011, 1'b0};
    vt[2] = '{32'h0000_0040, 32'h2041_0020, 1'b0};
    vt[3] = '{32'h0000_007C, 32'h2041_002F, 1'b0};
    vt[4] = '{32'h0000_0082, 32'h0000_0000, 1'b1};
    vt[5] = '{32'h0000_0080, 32'h0000_0000, 1'b1};
    vt[6] = '{32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[7] = '{32'h1000_0000, 32'h0000_0000, 1'b1};
    w3[0] = 32'hA000_0001;
    w3[1] = 32'hB000_0002;
    w3[2] = 32'hC000_0003;

    Clrn       = 1'b0;
    load_req   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 32'h0;
    ld_last    = 1'b0;
    fetch_addr = 32'h0000_0004;

    #2;
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_we", 32'(mif.we), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_inst", fetch_inst, 32'h0);

    tick();
    Clrn = 1'b1;
    repeat (5) tick();
    chk("idle_stall", 32'(cpu_stall), 32'd1);
    chk("idle_ready", 32'(ld_ready), 32'd0);
    chk("idle_inst", fetch_inst, 32'h0);

    // Full 32-word load
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("load_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h2041_0010 + 32'(i);
      ld_last  = (i == 31);
      #1;
      chk("full_waddr", 32'(mif.waddr), 32'(i));
      chk("full_we", 32'(mif.we), 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("full_done", 32'(ld_done), 32'd1);
    chk("full_run", 32'(cpu_stall), 32'd0);
    tick();
    chk("full_done_pulse", 32'(ld_done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      fetch_addr = vt[i].addr;
      #1;
      chk("vec_inst", fetch_inst, vt[i].inst);
      chk("vec_err", 32'(fetch_err), 32'(vt[i].err));
      chk("vec_raddr", 32'(mif.raddr),
          32'(vt[i].addr[6:2]));
    end

    // load_req coinciding with a fetch in RUN
    fetch_addr = 32'h0000_0004;
    load_req   = 1'b1;
    #1;
    chk("coin_inst", fetch_inst, 32'h2041_0011);
    chk("coin_stall", 32'(cpu_stall), 32'd0);
    tick();
    chk("coin_stall_nx", 32'(cpu_stall), 32'd1);
    chk("coin_inst_nx", fetch_inst, 32'h0);

    // Short load with gapped ld_valid
    for (int c = 0; c < 5; c++) begin
      if (c == 2) load_req = 1'b0;
      ld_valid = (c % 2 == 0);
      ld_data  = w3[c / 2];
      ld_last  = (c == 4);
      #1;
      if (c % 2 == 0)
        chk("gap_waddr", 32'(mif.waddr), 32'(c / 2));
      else
        chk("gap_we", 32'(mif.we), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("fill_waddr", 32'(mif.waddr), 32'd3);
    chk("fill_wdata", mif.wdata, 32'h0);
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (ld_done) break;
      if (mif.we) n++;
      tick();
    end
    chk("fill_cycles", 32'(n), 32'd29);
    chk("fill_done", 32'(ld_done), 32'd1);
    fetch_addr = 32'h0000_0010;
    #1;
    chk("short_nop", fetch_inst, 32'h0);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      #1;
      chk("short_word", fetch_inst, w3[i]);
    end
    fetch_addr = 32'h0000_000C;
    #1;
    chk("short_tail", fetch_inst, 32'h0);

    // Reset in the middle of a load at wcnt=10
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h5500_0000 + 32'(i);
      tick();
    end
    fetch_addr = 32'h0000_0000;
    #2;
    Clrn = 1'b0;
    #1;
    chk("abort_stall", 32'(cpu_stall), 32'd1);
    chk("abort_ready", 32'(ld_ready), 32'd0);
    chk("abort_we", 32'(mif.we), 32'd0);
    chk("abort_inst", fetch_inst, 32'h0);
    ld_valid = 1'b0;
    tick();
    Clrn = 1'b1;
    repeat (3) tick();
    chk("abort_idle", 32'(cpu_stall), 32'd1);

    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    ld_last  = 1'b1;
    #1;
    chk("reload_waddr", 32'(mif.waddr), 32'd0);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    wait_done("reload_done");
    fetch_addr = 32'h0000_0000;
    #1;
    chk("reload_w0", fetch_inst, 32'hDEAD_BEEF);
    fetch_addr = 32'h0000_0004;
    #1;
    chk("reload_w1", fetch_inst, 32'h0);
    fetch_addr = 32'h0000_0028;
    #1;
    chk("reload_w10", fetch_inst, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
